// File: rtl/mem_pkg.sv
// Shared encodings for the load/store RMW front-end: access sizes, FSM states
// and big-endian lane shift helpers.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    RESP
  } state_e;

  // Big-endian: byte offset 0 sits in the top lane, so shift = (3 - off) * 8.
  function automatic logic [4:0] byte_shift(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

  function automatic logic [4:0] half_shift(input logic hi);
    return {~hi, 4'b0000};
  endfunction

endpackage

// File: rtl/mem_lsu_rmw_if.sv
// Request/response handshake bundle between a requester and the LSU front-end.
interface mem_lsu_rmw_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatter: big-endian load extract with sign/zero extend,
// and sub-word store merge into a fetched memory word.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [HALF_W-1:0] wdata_i,
  output logic [WORD_W-1:0] load_o,
  output logic [WORD_W-1:0] merge_o
);

  logic [4:0]               bsh;
  logic [4:0]               hsh;
  logic [WORD_W-1:0]        bword;
  logic [WORD_W-1:0]        hword;
  logic [BYTE_W-1:0]        bval;
  logic [HALF_W-1:0]        hval;
  logic signed [BYTE_W-1:0] bval_s;
  logic signed [HALF_W-1:0] hval_s;
  logic [WORD_W-1:0]        bmask;
  logic [WORD_W-1:0]        hmask;

  always_comb begin
    bsh    = byte_shift(off_i);
    hsh    = half_shift(off_i[1]);
    bword  = word_i >> bsh;
    hword  = word_i >> hsh;
    bval   = bword[BYTE_W-1:0];
    hval   = hword[HALF_W-1:0];
    bval_s = bval;
    hval_s = hval;
    bmask  = {{(WORD_W-BYTE_W){1'b0}}, {BYTE_W{1'b1}}} << bsh;
    hmask  = {{(WORD_W-HALF_W){1'b0}}, {HALF_W{1'b1}}} << hsh;

    load_o  = '0;
    merge_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        if (unsigned_i) load_o = {{(WORD_W-BYTE_W){1'b0}}, bval};
        else            load_o = WORD_W'(bval_s);
        merge_o = (word_i & ~bmask) |
                  ({{(WORD_W-BYTE_W){1'b0}}, wdata_i[BYTE_W-1:0]} << bsh);
      end
      SZ_HALF: begin
        if (unsigned_i) load_o = {{(WORD_W-HALF_W){1'b0}}, hval};
        else            load_o = WORD_W'(hval_s);
        merge_o = (word_i & ~hmask) | ({{(WORD_W-HALF_W){1'b0}}, wdata_i} << hsh);
      end
      SZ_WORD: load_o = word_i;
      default: load_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_lsu_rmw.sv
// Load/store front-end for a single-port word memory: one request in flight,
// sub-word stores become an atomic read-modify-write, loads are aligned/extended.
module mem_lsu_rmw
  import mem_pkg::*;
#(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_lsu_rmw_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [ADDR_WIDTH-1:0] mem_addw,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_SIZE);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  we_q;
  logic                  unsigned_q;
  logic [1:0]            size_q;
  logic [1:0]            off_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept;
  logic                  req_bad;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] merge_val;

  assign accept = bus.req_valid && (state_q == IDLE);

  always_comb begin
    req_bad = 1'b0;
    case (bus.req_size)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = bus.req_addr[0];
      SZ_WORD: req_bad = |bus.req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
    if (bus.req_addr >= MEM_LIMIT) req_bad = 1'b1;
  end

  mem_lane_fmt u_fmt (
    .word_i     (mem_dout),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .wdata_i    (wdata_q[HALF_W-1:0]),
    .load_o     (load_val),
    .merge_o    (merge_val)
  );

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = '0;
          err_d   = req_bad;
          if (req_bad)                                  state_d = RESP;
          else if (bus.req_we && bus.req_size == SZ_WORD) state_d = WR;
          else                                          state_d = RD;
        end
      end
      RD:   state_d = WAIT;
      WAIT: begin
        if (!we_q) rdata_d = load_val;
        state_d = RESP;
      end
      WR:   state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write strobe comes from state alone so an async reset kills it at once.
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
    mem_addr      = addr_q;
    mem_addw      = addr_q;
    mem_we        = (state_q == WR) || ((state_q == WAIT) && we_q);
    mem_din       = '0;
    if (state_q == WR)                mem_din = wdata_q;
    else if (state_q == WAIT && we_q) mem_din = merge_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) addr_q <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q       <= bus.req_we;
      unsigned_q <= bus.req_unsigned;
      size_q     <= bus.req_size;
      off_q      <= bus.req_addr[1:0];
      wdata_q    <= bus.req_wdata;
    end
  end

endmodule

// File: tb/tb_mem_lsu_rmw.sv
// Directed bench for mem_lsu_rmw with a behavioural single-port word memory.
module tb_mem_lsu_rmw;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr, mem_addw, mem_din;
  logic        mem_we;
  logic [31:0] mem_dout = '0;
  logic [31:0] mem [0:1023];

  int          n_vec = 0;
  int          n_miss = 0;
  int          we_total = 0;
  int          we_double = 0;
  logic        we_prev = 1'b0;
  logic [31:0] last_addw = '0;
  logic [31:0] last_din = '0;

  mem_lsu_rmw_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_lsu_rmw #(.MEM_SIZE(4096), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_addw (mem_addw),
    .mem_we   (mem_we),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addw[11:2]] <= mem_din;
    mem_dout <= mem[mem_addr[11:2]];
  end

  always @(negedge clk) begin
    if (mem_we) begin
      we_total  <= we_total + 1;
      last_addw <= mem_addw;
      last_din  <= mem_din;
    end
    if (mem_we && we_prev) we_double <= we_double + 1;
    we_prev <= mem_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic do_req(input string nm, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input int exp_lat, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_we);
    int          lat;
    int          we0;
    logic        first_we;
    logic [31:0] rd;
    logic        er;
    chk({nm, "/req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    we0      = we_total;
    first_we = 1'b0;
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.req_valid = 1'b0;
        first_we      = mem_we;
      end
      if (bus.rsp_valid) break;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    chk({nm, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "/rdata"}, rd, exp_rdata);
    chk({nm, "/err"}, 32'(er), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "/hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({nm, "/hold_rdata"}, bus.rsp_rdata, rd);
      chk({nm, "/hold_err"}, 32'(bus.rsp_err), 32'(er));
      chk({nm, "/hold_req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({nm, "/rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
    chk({nm, "/we_count"}, 32'(we_total - we0), 32'(exp_we));
    if (exp_we > 0) chk({nm, "/addw"}, last_addw, addr & 32'hFFFF_FFFC);
    if (we && sz == SZ_WORD && !exp_err) chk({nm, "/we_first"}, 32'(first_we), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[8] = 32'h80FF7F01;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = SZ_WORD;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst/req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst/rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst/rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst/mem_we", 32'(mem_we), 32'd0);
    chk("rst/mem_addr", mem_addr, 32'd0);
    chk("rst/mem_addw", mem_addw, 32'd0);
    chk("rst/mem_din", mem_din, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req("LB20",  1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, 0, 3, 32'hFFFFFF80, 1'b0, 0);
    do_req("LBU20", 1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, 0, 3, 32'h00000080, 1'b0, 0);
    do_req("LH22",  1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 0, 3, 32'h00007F01, 1'b0, 0);
    do_req("LH20",  1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, 0, 3, 32'hFFFF80FF, 1'b0, 0);
    do_req("LBU23", 1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0, 0, 3, 32'h00000001, 1'b0, 0);

    do_req("SB21", 1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h123456AB, 0, 3, 32'h0, 1'b0, 1);
    chk("SB21/din", last_din, 32'h80AB7F01);
    chk("SB21/mem", mem[8], 32'h80AB7F01);

    do_req("SH26", 1'b1, SZ_HALF, 1'b0, 32'h26, 32'hFFFFCAFE, 0, 3, 32'h0, 1'b0, 1);
    chk("SH26/din", last_din, 32'h0000CAFE);

    do_req("SW24", 1'b1, SZ_WORD, 1'b0, 32'h24, 32'hDEADBEEF, 0, 2, 32'h0, 1'b0, 1);
    chk("SW24/din", last_din, 32'hDEADBEEF);
    do_req("LW24", 1'b0, SZ_WORD, 1'b0, 32'h24, 32'h0, 0, 3, 32'hDEADBEEF, 1'b0, 0);

    do_req("ELH21",  1'b0, SZ_HALF, 1'b0, 32'h21,   32'h0,      0, 1, 32'h0, 1'b1, 0);
    do_req("ESW22",  1'b1, SZ_WORD, 1'b0, 32'h22,   32'h11111111, 0, 1, 32'h0, 1'b1, 0);
    do_req("ELW1000", 1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0,      0, 1, 32'h0, 1'b1, 0);
    do_req("ESZ11",  1'b1, 2'b11,   1'b0, 32'h20,   32'h22222222, 0, 1, 32'h0, 1'b1, 0);
    chk("err/mem_intact", mem[8], 32'h80AB7F01);

    do_req("LWhold", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 5, 3, 32'h80AB7F01, 1'b0, 0);
    do_req("LBb2b",  1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, 0, 3, 32'hFFFFFFAB, 1'b0, 0);

    // Reset in the WAIT cycle of a sub-word store must drop the write.
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = SZ_BYTE;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h21;
    bus.req_wdata    = 32'h00000055;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rstmid/we_before", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid/mem_we", 32'(mem_we), 32'd0);
    chk("rstmid/req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstmid/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstmid/mem_addr", mem_addr, 32'd0);
    chk("rstmid/mem_din", mem_din, 32'd0);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid/mem", mem[8], 32'h80AB7F01);
    rst_n = 1'b1;
    @(negedge clk);
    do_req("LWpost", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 0, 3, 32'h80AB7F01, 1'b0, 0);

    chk("we_single_cycle", 32'(we_double), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
